// File: rtl/game_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_control_if                                                      |
// | Handshake bundle between keyboard/datapath and the game sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface game_control_if;
  logic       key_valid;
  logic       key_enter;
  logic       graph_loaded;
  logic       dash_done;
  logic       loopend;
  logic       match;
  logic       filled;
  logic       part_done;
  logic       clear_done;
  logic       remain_zero;
  logic       timeout;

  logic       ld;
  logic       wren;
  logic       ld_g;
  logic       writeorread;
  logic       compare;
  logic       rden;
  logic       fill;
  logic       draw;
  logic       over;
  logic       timecount;
  logic [4:0] word_len;
  logic [2:0] part;
  logic       win;
  logic       lose;
  logic       busy;

  // Sequencer side
  modport master (
    input  key_valid, key_enter, graph_loaded, dash_done, loopend, match,
           filled, part_done, clear_done, remain_zero, timeout,
    output ld, wren, ld_g, writeorread, compare, rden, fill, draw, over,
           timecount, word_len, part, win, lose, busy
  );

  // Keyboard/datapath side
  modport slave (
    output key_valid, key_enter, graph_loaded, dash_done, loopend, match,
           filled, part_done, clear_done, remain_zero, timeout,
    input  ld, wren, ld_g, writeorread, compare, rden, fill, draw, over,
           timecount, word_len, part, win, lose, busy
  );
endinterface
`default_nettype wire

// File: rtl/game_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_control                                                         |
// | Hangman round sequencer: one datapath phase enable at a time.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module game_control #(
  parameter int MAX_LEN  = 16,
  parameter int MAX_MISS = 6
) (
  input  logic          clk,
  input  logic          resetn,
  game_control_if.master bus
);

  localparam logic [4:0] C_LEN_MAX  = 5'(MAX_LEN);
  localparam logic [2:0] C_MISS_MAX = 3'(MAX_MISS);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    GRAPH   = 4'd2,
    DASH    = 4'd3,
    GUESS   = 4'd4,
    COMPARE = 4'd5,
    FILL    = 4'd6,
    DRAW    = 4'd7,
    CHECK   = 4'd8,
    CLEAR   = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] word_len_q, word_len_d;
  logic [2:0] part_q, part_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       ld_q, ld_d;

  logic ld_g_q, wor_q, compare_q, fill_q, draw_q, over_q, timecount_q, busy_q;
  logic ld_g_d, wor_d, compare_d, fill_d, draw_d, over_d, timecount_d, busy_d;

  always_comb begin
    state_d    = state_q;
    word_len_d = word_len_q;
    part_d     = part_q;
    win_d      = win_q;
    lose_d     = lose_q;
    ld_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.key_enter) state_d = LOAD;
      end
      LOAD: begin
        // Enter takes priority over a simultaneous character strobe
        if (bus.key_enter) begin
          if (word_len_q != 5'd0) state_d = GRAPH;
        end else if (bus.key_valid && (word_len_q < C_LEN_MAX)) begin
          ld_d       = 1'b1;
          word_len_d = word_len_q + 5'd1;
        end
      end
      GRAPH: begin
        if (bus.graph_loaded) state_d = DASH;
      end
      DASH: begin
        if (bus.dash_done) state_d = GUESS;
      end
      GUESS: begin
        if (bus.timeout) begin
          state_d = CLEAR;
          lose_d  = 1'b1;
        end else if (bus.key_valid) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.loopend) state_d = bus.match ? FILL : DRAW;
      end
      FILL: begin
        if (bus.filled) state_d = CHECK;
      end
      DRAW: begin
        if (bus.part_done) begin
          state_d = CHECK;
          if (part_q < C_MISS_MAX) part_d = part_q + 3'd1;
        end
      end
      CHECK: begin
        if (bus.remain_zero) begin
          state_d = CLEAR;
          win_d   = 1'b1;
        end else if (part_q == C_MISS_MAX) begin
          state_d = CLEAR;
          lose_d  = 1'b1;
        end else begin
          state_d = GUESS;
        end
      end
      CLEAR: begin
        if (bus.clear_done) state_d = DONE;
      end
      DONE: begin
        if (bus.key_enter) begin
          state_d    = IDLE;
          word_len_d = 5'd0;
          part_d     = 3'd0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables are registered from the next state so they track the state register exactly
  assign ld_g_d      = (state_d == GRAPH);
  assign wor_d       = (state_d == DASH);
  assign compare_d   = (state_d == COMPARE);
  assign fill_d      = (state_d == FILL);
  assign draw_d      = (state_d == DRAW);
  assign over_d      = (state_d == CLEAR);
  assign timecount_d = (state_d == GUESS) || (state_d == COMPARE) ||
                       (state_d == FILL)  || (state_d == DRAW)    ||
                       (state_d == CHECK);
  assign busy_d      = (state_d != IDLE) && (state_d != DONE);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= IDLE;
      word_len_q  <= 5'd0;
      part_q      <= 3'd0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      ld_q        <= 1'b0;
      ld_g_q      <= 1'b0;
      wor_q       <= 1'b0;
      compare_q   <= 1'b0;
      fill_q      <= 1'b0;
      draw_q      <= 1'b0;
      over_q      <= 1'b0;
      timecount_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_len_q  <= word_len_d;
      part_q      <= part_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      ld_q        <= ld_d;
      ld_g_q      <= ld_g_d;
      wor_q       <= wor_d;
      compare_q   <= compare_d;
      fill_q      <= fill_d;
      draw_q      <= draw_d;
      over_q      <= over_d;
      timecount_q <= timecount_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ld          = ld_q;
  assign bus.wren        = ld_q;
  assign bus.ld_g        = ld_g_q;
  assign bus.writeorread = wor_q;
  assign bus.compare     = compare_q;
  assign bus.rden        = compare_q;
  assign bus.fill        = fill_q;
  assign bus.draw        = draw_q;
  assign bus.over        = over_q;
  assign bus.timecount   = timecount_q;
  assign bus.word_len    = word_len_q;
  assign bus.part        = part_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_game_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_game_control                                                      |
// | Directed scenarios plus random stimulus against a phase-name model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_game_control;

  localparam int MAX_LEN  = 16;
  localparam int MAX_MISS = 6;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   run_chk = 1'b0;

  game_control_if bus ();

  game_control #(.MAX_LEN(MAX_LEN), .MAX_MISS(MAX_MISS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: round progress held as a phase name
  string ph     = "IDLE";
  int    m_len  = 0;
  int    m_part = 0;
  bit    m_win  = 0;
  bit    m_lose = 0;
  bit    m_ld   = 0;

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ph <= "IDLE"; m_len <= 0; m_part <= 0; m_win <= 0; m_lose <= 0; m_ld <= 0;
    end else begin
      m_ld <= 0;
      if (ph == "IDLE") begin
        if (bus.key_enter) ph <= "LOAD";
      end else if (ph == "LOAD") begin
        if (bus.key_enter) begin
          if (m_len >= 1) ph <= "GRAPH";
        end else if (bus.key_valid && m_len < MAX_LEN) begin
          m_len <= m_len + 1; m_ld <= 1;
        end
      end else if (ph == "GRAPH") begin
        if (bus.graph_loaded) ph <= "DASH";
      end else if (ph == "DASH") begin
        if (bus.dash_done) ph <= "GUESS";
      end else if (ph == "GUESS") begin
        if (bus.timeout) begin ph <= "CLEAR"; m_lose <= 1; end
        else if (bus.key_valid) ph <= "COMPARE";
      end else if (ph == "COMPARE") begin
        if (bus.loopend) ph <= bus.match ? "FILL" : "DRAW";
      end else if (ph == "FILL") begin
        if (bus.filled) ph <= "CHECK";
      end else if (ph == "DRAW") begin
        if (bus.part_done) begin
          ph <= "CHECK";
          m_part <= (m_part < MAX_MISS) ? m_part + 1 : m_part;
        end
      end else if (ph == "CHECK") begin
        if (bus.remain_zero) begin ph <= "CLEAR"; m_win <= 1; end
        else if (m_part == MAX_MISS) begin ph <= "CLEAR"; m_lose <= 1; end
        else ph <= "GUESS";
      end else if (ph == "CLEAR") begin
        if (bus.clear_done) ph <= "DONE";
      end else if (ph == "DONE") begin
        if (bus.key_enter) begin
          ph <= "IDLE"; m_len <= 0; m_part <= 0; m_win <= 0; m_lose <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk && !resetn) begin
      check("ld",          int'(bus.ld),          int'(m_ld));
      check("wren",        int'(bus.wren),        int'(m_ld));
      check("ld_g",        int'(bus.ld_g),        int'(ph == "GRAPH"));
      check("writeorread", int'(bus.writeorread), int'(ph == "DASH"));
      check("compare",     int'(bus.compare),     int'(ph == "COMPARE"));
      check("rden",        int'(bus.rden),        int'(ph == "COMPARE"));
      check("fill",        int'(bus.fill),        int'(ph == "FILL"));
      check("draw",        int'(bus.draw),        int'(ph == "DRAW"));
      check("over",        int'(bus.over),        int'(ph == "CLEAR"));
      check("timecount",   int'(bus.timecount),
            int'(ph == "GUESS" || ph == "COMPARE" || ph == "FILL" || ph == "DRAW" || ph == "CHECK"));
      check("busy",        int'(bus.busy),        int'(ph != "IDLE" && ph != "DONE"));
      check("word_len",    int'(bus.word_len),    m_len);
      check("part",        int'(bus.part),        m_part);
      check("win",         int'(bus.win),         int'(m_win));
      check("lose",        int'(bus.lose),        int'(m_lose));
      check("win_lose_excl", int'(bus.win & bus.lose), 0);
    end
  end

  task automatic clr();
    bus.key_valid = 0; bus.key_enter = 0; bus.graph_loaded = 0; bus.dash_done = 0;
    bus.loopend = 0; bus.match = 0; bus.filled = 0; bus.part_done = 0;
    bus.clear_done = 0; bus.remain_zero = 0; bus.timeout = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic start_round(input int n);
    bus.key_enter = 1; step();
    for (int i = 0; i < n; i++) begin bus.key_valid = 1; step(); end
    bus.key_enter = 1; step();
    bus.graph_loaded = 1; step();
    bus.dash_done = 1; step();
  endtask

  task automatic miss();
    bus.key_valid = 1; step();
    bus.loopend = 1; bus.match = 0; step();
    bus.part_done = 1; step();
  endtask

  int npulse;

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #2 resetn = 0;
    run_chk = 1;
    step();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_word_len", int'(bus.word_len), 0);

    // Empty word and Enter/key collision stay in LOAD
    bus.key_enter = 1; step();
    check("load_busy", int'(bus.busy), 1);
    bus.key_enter = 1; step();
    check("empty_enter_ld_g", int'(bus.ld_g), 0);
    bus.key_enter = 1; bus.key_valid = 1; step();
    check("collide_len", int'(bus.word_len), 0);
    check("collide_ld", int'(bus.ld), 0);

    // Three characters spaced two cycles apart
    for (int i = 0; i < 3; i++) begin
      bus.key_valid = 1; step();
      check("load_pulse", int'(bus.ld), 1);
      check("load_len", int'(bus.word_len), i + 1);
      step();
      check("load_pulse_end", int'(bus.wren), 0);
    end
    bus.key_enter = 1; step();
    check("graph_ld_g", int'(bus.ld_g), 1);
    check("graph_len", int'(bus.word_len), 3);
    bus.graph_loaded = 1; step();
    check("dash_wor", int'(bus.writeorread), 1);
    bus.dash_done = 1; step();
    check("guess_timecount", int'(bus.timecount), 1);

    // Hit path to a win
    bus.key_valid = 1; step();
    check("hit_compare", int'(bus.compare), 1);
    bus.loopend = 1; bus.match = 1; step();
    check("hit_fill", int'(bus.fill), 1);
    bus.filled = 1; bus.remain_zero = 1; step();
    check("hit_check_fill", int'(bus.fill), 0);
    check("hit_check_tc", int'(bus.timecount), 1);
    bus.remain_zero = 1; step();
    check("hit_over", int'(bus.over), 1);
    check("hit_win", int'(bus.win), 1);
    repeat (3) step();
    check("hit_over_hold", int'(bus.over), 1);
    bus.clear_done = 1; step();
    check("done_busy", int'(bus.busy), 0);
    check("done_win", int'(bus.win), 1);
    bus.key_enter = 1; step();
    check("idle_win_clr", int'(bus.win), 0);

    // Overflow: 18 keys, 16 stored
    bus.key_enter = 1; step();
    npulse = 0;
    for (int i = 0; i < 18; i++) begin
      bus.key_valid = 1; step();
      if (bus.ld) npulse++;
    end
    check("ovf_pulses", npulse, 16);
    check("ovf_len", int'(bus.word_len), 16);
    bus.key_enter = 1; step();
    check("ovf_ld_g", int'(bus.ld_g), 1);
    #1 resetn = 1; #1 resetn = 0;

    // Six misses end in a loss
    start_round(2);
    for (int i = 1; i <= MAX_MISS; i++) begin
      miss();
      check("loss_part", int'(bus.part), i);
      step();
    end
    check("loss_lose", int'(bus.lose), 1);
    check("loss_over", int'(bus.over), 1);
    check("loss_win", int'(bus.win), 0);
    bus.clear_done = 1; step();
    bus.key_enter = 1; step();

    // Key and timeout together in GUESS
    start_round(1);
    bus.key_valid = 1; bus.timeout = 1; step();
    check("to_compare", int'(bus.compare), 0);
    check("to_over", int'(bus.over), 1);
    check("to_lose", int'(bus.lose), 1);
    bus.clear_done = 1; step();
    bus.key_enter = 1; step();

    // Asynchronous reset in the middle of DRAW
    start_round(1);
    miss(); step();
    bus.key_valid = 1; step();
    bus.loopend = 1; step();
    check("ar_draw", int'(bus.draw), 1);
    check("ar_part", int'(bus.part), 1);
    #1 resetn = 1;
    #1;
    check("ar_draw_drop", int'(bus.draw), 0);
    check("ar_part_drop", int'(bus.part), 0);
    check("ar_busy_drop", int'(bus.busy), 0);
    @(posedge clk);
    #2 resetn = 0;
    bus.key_enter = 1; step();
    check("ar_load", int'(bus.busy), 1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus.key_valid    = ($urandom_range(0, 99) < 30);
      bus.key_enter    = ($urandom_range(0, 99) < 10);
      bus.graph_loaded = ($urandom_range(0, 99) < 40);
      bus.dash_done    = ($urandom_range(0, 99) < 40);
      bus.loopend      = ($urandom_range(0, 99) < 30);
      bus.match        = ($urandom_range(0, 99) < 50);
      bus.filled       = ($urandom_range(0, 99) < 40);
      bus.part_done    = ($urandom_range(0, 99) < 40);
      bus.clear_done   = ($urandom_range(0, 99) < 40);
      bus.remain_zero  = ($urandom_range(0, 99) < 25);
      bus.timeout      = ($urandom_range(0, 99) < 4);
      @(posedge clk);
      #2;
      if ($urandom_range(0, 999) == 0) begin
        resetn = 1; #1 resetn = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
